// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
//   Types and helpers shared by the CNN datapath blocks.
//   DATA_W  : signed pixel width produced by the conv processing element
//   pixel_t : one signed pixel
//   pix_max : signed maximum of two pixels (no width growth)
//   relu    : clamps negative pixels to zero
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] pixel_t;

  function automatic pixel_t pix_max(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

  // The sign bit alone decides the clamp, so no comparator is needed.
  function automatic pixel_t relu(input pixel_t x);
    return x[DATA_W-1] ? pixel_t'(0) : x;
  endfunction

endpackage

// File: rtl/relu_maxpool2x2_pool_line_buf.sv
// ---------------------------------------------------------------------------
// pool_line_buf
//   Holds the horizontal maxima of the even (top) row of every 2x2 window
//   until the matching odd (bottom) row arrives. One entry per window column.
//   The array has no reset: each entry is always written on the even row
//   before it is read on the odd row.
//
//   clk     : rising-edge clock
//   i_we    : write enable
//   i_waddr : write entry (window column)
//   i_wdata : horizontal max of the top row pair
//   i_raddr : read entry (window column)
//   o_rdata : stored top-row max, combinational read
// ---------------------------------------------------------------------------
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 13,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  pixel_t        i_wdata,
  input  logic [AW-1:0] i_raddr,
  output pixel_t        o_rdata
);

  pixel_t r_mem [DEPTH];

  // One enable-decoded register per entry.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (i_we && (i_waddr == AW'(gi))) begin
          r_mem[gi] <= i_wdata;
        end
      end
    end
  endgenerate

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/relu_maxpool2x2.sv
// ---------------------------------------------------------------------------
// relu_maxpool2x2
//   Streaming ReLU followed by 2x2 / stride-2 max pooling over a raster-order
//   IMG_W x IMG_H conv output map. One pooled pixel per window is presented
//   through a single valid/ready output register.
//
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   clear      : synchronous frame restart (drops any pending output)
//   in_data    : signed conv result
//   in_valid   : in_data present
//   ready_pool : stage accepts in_data this cycle (stalls the conv PE)
//   out_data   : pooled pixel, never negative
//   out_valid  : out_data valid, held until accepted
//   out_ready  : downstream accepts out_data
//   frame_done : pulse on the handshake of the last window of a frame
// ---------------------------------------------------------------------------
module relu_maxpool2x2
  import cnn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     ready_pool,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_done
);

  localparam int HALF_W = IMG_W / 2;
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int KW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  generate
    if ((IMG_W % 2) != 0) begin : g_bad_img_w
      $error("relu_maxpool2x2: IMG_W must be even");
    end
    if ((IMG_H % 2) != 0) begin : g_bad_img_h
      $error("relu_maxpool2x2: IMG_H must be even");
    end
    if (DATA_W != cnn_pkg::DATA_W) begin : g_bad_data_w
      $error("relu_maxpool2x2: DATA_W must match cnn_pkg::DATA_W");
    end
  endgenerate

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  pixel_t        r_h;
  pixel_t        r_out_data;
  logic          r_out_valid;
  logic          r_out_last;

  logic          w_acc;
  logic          w_col_odd;
  logic          w_row_odd;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_lb_we;
  logic [KW-1:0] w_k;
  pixel_t        w_in_pix;
  pixel_t        w_relu;
  pixel_t        w_hmax;
  pixel_t        w_lb_rdata;
  pixel_t        w_win_max;

  // The single output slot frees up in the same cycle it is accepted,
  // which keeps throughput at one sample per cycle under out_ready=1.
  assign ready_pool = !r_out_valid || out_ready;
  assign w_acc      = in_valid && ready_pool;

  assign w_col_odd  = r_col[0];
  assign w_row_odd  = r_row[0];
  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_row_last = (r_row == RW'(IMG_H - 1));
  assign w_k        = KW'(r_col >> 1);

  assign w_in_pix   = in_data;
  assign w_relu     = relu(w_in_pix);
  assign w_hmax     = pix_max(r_h, w_relu);
  assign w_win_max  = pix_max(w_lb_rdata, w_hmax);

  // Top row of each window parks its horizontal max here.
  assign w_lb_we    = w_acc && w_col_odd && !w_row_odd;

  pool_line_buf #(
    .DEPTH (HALF_W),
    .AW    (KW)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_k),
    .i_wdata (w_hmax),
    .i_raddr (w_k),
    .o_rdata (w_lb_rdata)
  );

  // Raster position and left-pixel holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
      r_h   <= '0;
    end else if (clear) begin
      r_col <= '0;
      r_row <= '0;
      r_h   <= '0;
    end else if (w_acc) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      if (!w_col_odd) begin
        r_h <= w_relu;
      end
    end
  end

  // Output slot: a completed window loads it (even while the previous
  // result is being accepted); otherwise a handshake empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_acc && w_col_odd && w_row_odd) begin
      r_out_data  <= w_win_max;
      r_out_valid <= 1'b1;
      r_out_last  <= w_row_last && w_col_last;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign frame_done = r_out_valid && out_ready && r_out_last;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
module tb_relu_maxpool2x2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 4x4 instance
  logic               a_clear, a_in_valid, a_out_ready;
  logic signed [15:0] a_in_data;
  logic               a_ready_pool, a_out_valid, a_frame_done;
  logic signed [15:0] a_out_data;

  // 2x2 instance
  logic               b_clear, b_in_valid, b_out_ready;
  logic signed [15:0] b_in_data;
  logic               b_ready_pool, b_out_valid, b_frame_done;
  logic signed [15:0] b_out_data;

  relu_maxpool2x2 #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .clear      (a_clear),
    .in_data    (a_in_data),
    .in_valid   (a_in_valid),
    .ready_pool (a_ready_pool),
    .out_data   (a_out_data),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .frame_done (a_frame_done)
  );

  relu_maxpool2x2 #(.DATA_W(16), .IMG_W(2), .IMG_H(2)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .clear      (b_clear),
    .in_data    (b_in_data),
    .in_valid   (b_in_valid),
    .ready_pool (b_ready_pool),
    .out_data   (b_out_data),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .frame_done (b_frame_done)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [15:0] din;
    logic               exp_valid;
    int                 exp_data;
    logic               exp_fd;
  } vec_t;

  vec_t tbl [32];

  // reference model state (4x4 frame)
  int m_img [4][4];
  int m_n;
  bit m_pend;
  int m_val;
  bit m_last;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clear_a();
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
  endtask

  // Drive table rows [first, first+n) one per cycle with out_ready=1.
  task automatic run_table(input int first, input int n, input string tag);
    for (int i = first; i < first + n; i++) begin
      a_in_valid  = 1'b1;
      a_in_data   = tbl[i].din;
      a_out_ready = 1'b1;
      tick();
      chk({tag, "_valid"}, a_out_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk({tag, "_data"}, a_out_data, tbl[i].exp_data);
      chk({tag, "_frame_done"}, a_frame_done, tbl[i].exp_fd);
      $display("%s vec %0d in=%0d out_valid=%0b out_data=%0d frame_done=%0b",
               tag, i, tbl[i].din, a_out_valid, a_out_data, a_frame_done);
    end
    a_in_valid = 1'b0;
  endtask

  // One model-checked cycle on the 4x4 instance.
  task automatic step_m(input logic v, input logic signed [15:0] d, input logic rdy);
    bit exp_ready, acc;
    int r, c, rv;
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = rdy;
    #1;
    exp_ready = !m_pend || rdy;
    acc = v && exp_ready;
    chk("rnd_ready_pool", a_ready_pool, exp_ready);
    chk("rnd_out_valid", a_out_valid, m_pend);
    if (m_pend) chk("rnd_out_data", a_out_data, m_val);
    chk("rnd_frame_done", a_frame_done, m_pend && rdy && m_last);
    if (m_pend && rdy) begin
      $display("rnd out %0d last=%0b", a_out_data, m_last);
      m_pend = 1'b0;
    end
    if (acc) begin
      r  = (m_n / 4) % 4;
      c  = m_n % 4;
      rv = (d < 0) ? 0 : int'(d);
      m_img[r][c] = rv;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        m_val  = imax(imax(m_img[r-1][c-1], m_img[r-1][c]), imax(m_img[r][c-1], rv));
        m_pend = 1'b1;
        m_last = (r == 3) && (c == 3);
      end
      m_n++;
    end
    @(posedge clk);
    #1;
  endtask

  logic signed [15:0] bvals [4];

  initial begin
    // ramp 1..16 then all -5
    for (int i = 0; i < 32; i++) begin
      int p;
      p = i % 16;
      tbl[i].din       = (i < 16) ? 16'(i + 1) : -16'sd5;
      tbl[i].exp_valid = (p == 5) || (p == 7) || (p == 13) || (p == 15);
      tbl[i].exp_data  = (i < 16) ? i + 1 : 0;
      tbl[i].exp_fd    = (p == 15);
    end
    bvals[0] = -16'sd3;
    bvals[1] = 16'sd7;
    bvals[2] = 16'sd100;
    bvals[3] = -16'sd32768;

    reset = 1'b1;
    a_clear = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_data = '0;
    b_clear = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_frame_done", a_frame_done, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_ready_pool", a_ready_pool, 1);
    tick();

    // clean ramp frame, then all-negative frame
    run_table(0, 16, "ramp");
    run_table(16, 16, "neg");

    // single-window 2x2 frame
    for (int j = 0; j < 4; j++) begin
      b_in_valid = 1'b1;
      b_in_data  = bvals[j];
      tick();
      chk("w2x2_valid", b_out_valid, (j == 3) ? 1 : 0);
      $display("w2x2 vec %0d in=%0d out_valid=%0b out_data=%0d", j, bvals[j], b_out_valid, b_out_data);
    end
    b_in_valid = 1'b0;
    chk("w2x2_data", b_out_data, 100);
    chk("w2x2_frame_done", b_frame_done, 1);

    // backpressure: stall after the first output, then resume
    clear_a();
    run_table(0, 6, "bp_pre");
    a_in_valid = 1'b1;
    a_in_data  = 16'sd7;
    a_out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("bp_ready_low", a_ready_pool, 0);
      tick();
      chk("bp_hold_valid", a_out_valid, 1);
      chk("bp_hold_data", a_out_data, 6);
      $display("bp stall %0d out_valid=%0b out_data=%0d", s, a_out_valid, a_out_data);
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp_ready_resume", a_ready_pool, 1);
    tick();
    chk("bp_drained", a_out_valid, 0);
    run_table(7, 9, "bp_post");

    // clear mid-frame after 5 samples; sample coincident with clear dropped
    clear_a();
    run_table(0, 5, "clr_pre");
    a_in_valid = 1'b1;
    a_in_data  = 16'sd99;
    a_clear    = 1'b1;
    tick();
    a_clear    = 1'b0;
    a_in_valid = 1'b0;
    chk("clr_out_valid", a_out_valid, 0);
    run_table(0, 16, "clr_post");

    // asynchronous reset while an output is pending
    clear_a();
    run_table(0, 6, "ar_pre");
    a_out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_out_valid", a_out_valid, 0);
    chk("ar_ready_pool", a_ready_pool, 1);
    chk("ar_out_data", a_out_data, 0);
    #1 reset = 1'b0;
    a_out_ready = 1'b1;
    tick();
    run_table(0, 16, "ar_post");

    // randomized traffic against the reference model
    clear_a();
    m_n = 0; m_pend = 1'b0; m_val = 0; m_last = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m_img[r][c] = 0;
    for (int t = 0; t < 600; t++) begin
      step_m(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
             16'($urandom),
             ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
    end
    for (int t = 0; t < 3; t++) step_m(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/relu_maxpool2x2.md
Name: relu_maxpool2x2

Overview:
- Streaming ReLU + 2x2/stride-2 max-pool stage sitting directly downstream of the conv processing element.
- Consumes one conv result per `in_valid` pulse in raster order (row-major over an IMG_W x IMG_H conv output map).
- Emits one pooled pixel per 2x2 window through a valid/ready output register.
- Drives `ready_pool` back to the conv PE so that its accumulation counter stalls while this stage is backpressured.

Parameters:
- DATA_W, 16, signed pixel width; matches conv PE output.
- IMG_W, 26, conv output map width. Must be even (elaboration-time assertion).
- IMG_H, 26, conv output map height. Must be even (elaboration-time assertion).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- clear, input, 1, synchronous frame restart: zeroes counters and drops any pending output.
- in_data, input, DATA_W, signed conv result; driven from conv PE output_featuremap.
- in_valid, input, 1, input sample present; driven from conv PE flag.
- ready_pool, output, 1, stage can accept in_data this cycle.
- out_data, output, DATA_W, signed pooled pixel (always >= 0).
- out_valid, output, 1, out_data valid; held until accepted.
- out_ready, input, 1, downstream accepts out_data.
- frame_done, output, 1, one-cycle pulse when the last pooled pixel of a frame is accepted downstream.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, frame_done=0. All counters, parity bits and line-buffer valid state are cleared. ready_pool=1 once reset deasserts.
- Accept rule: `acc = in_valid & ready_pool`.
  - `ready_pool = !out_valid | out_ready` (combinational).
  - in_valid while ready_pool=0 is ignored. The conv PE holds its sum because it also sees ready_pool low.
- ReLU: `r = in_data[DATA_W-1] ? 0 : in_data`. All comparisons are signed DATA_W; no width growth.
- Counters:
  - col (0..IMG_W-1) and row (0..IMG_H-1) advance on acc only.
  - col wraps to 0 and row increments at col==IMG_W-1.
  - row wraps to 0 at the end of the frame.
- Horizontal pair:
  - col even: latch r into h_reg.
  - col odd: `hmax = max(h_reg, r)`, with k = col>>1.
- Even row, col odd: `linebuf[k] = hmax`. No output.
- Odd row, col odd: `out_data <= max(linebuf[k], hmax)` and `out_valid <= 1` on the next edge. Latency is 1 cycle from accepting the bottom-right pixel of the window.
- Output hold: out_valid stays 1 and out_data stays stable until `out_valid & out_ready`.
  - A new output may load in the same cycle the old one is accepted, which gives back-to-back throughput.
  - Only one output slot exists. ready_pool therefore falls only while an unaccepted result is pending.
- frame_done: pulses for the output handshake of window (IMG_H/2-1, IMG_W/2-1). Counters have already wrapped to 0/0 at that pixel's acceptance.
- clear: highest priority after reset.
  - Counters go to 0, out_valid goes to 0, h_reg goes to 0.
  - linebuf contents don't-care, since they are overwritten before being read.
  - clear together with in_valid: the sample is dropped.
- Reset mid-frame: same as clear, but asynchronous. The next accepted sample is pixel (0,0).
- Window boundaries: windows never straddle row pairs, and IMG_W/IMG_H are even, so no partial windows exist.

Decomposition:
- cnn_pkg (shared) holds:
  - `localparam DATA_W=16`
  - `typedef logic signed [DATA_W-1:0] pixel_t`
  - function `pix_max(pixel_t a, pixel_t b)`
  - function `relu(pixel_t x)`
- Sub-module pool_line_buf:
  - IMG_W/2 x DATA_W register array.
  - Write port: we, waddr, wdata. Read port: raddr, combinational rdata.
  - Reset-free.
- Top level holds the counters, h_reg, the output register and the handshake.

Test Plan:
- Parameters IMG_W=4, IMG_H=4, out_ready=1; stream values 1..16 in raster order -> four outputs 6, 8, 14, 16, each 1 cycle after pixels 6, 8, 14, 16; frame_done with the last output.
- All-negative frame (every in_data = -5) -> four outputs of value 0; no sign bit ever set on out_data.
- Window [-3, 7; 100, -32768] in a single 2x2 frame (IMG_W=IMG_H=2) -> out_data=100.
- Backpressure: hold out_ready=0 after the first output with in_valid=1 continuous -> out_valid stays 1, out_data frozen, ready_pool=0, col/row unchanged. Raise out_ready -> the next sample is accepted that same cycle and no sample is lost.
- Assert clear mid-frame after 5 samples, then stream a fresh 4x4 ramp -> outputs match the clean-frame values 6, 8, 14, 16.
- Async reset pulse between clock edges while out_valid=1 -> out_valid=0 immediately, ready_pool=1; the following frame behaves as in the first scenario.
